drum_sequencer: RTL and testbench

//  Multi-channel step sequencer: successor to the per-drum controller array.

---
 rtl/drum_seq_pkg.sv | 9 +
 rtl/drum_channel.sv | 40 ++++
 rtl/drum_sequencer.sv | 96 +++++++++
 tb/tb_drum_sequencer.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/drum_seq_pkg.sv
// drum_seq_pkg: shared types and helpers for the drum step sequencer
package drum_seq_pkg;
  typedef enum logic {IDLE, RUN} seq_state_e;
  localparam int PATTERN_W = 8;
  typedef logic [PATTERN_W-1:0] pattern_t;
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/drum_channel.sv
// drum_channel: active/shadow pattern pair with pending flag and trigger lookup for one drum
module drum_channel
  import drum_seq_pkg::*;
#(
  parameter int PATTERN_WIDTH = PATTERN_W,
  parameter int COUNT_WIDTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_i,
  input  logic                     commit_i,
  input  logic [PATTERN_WIDTH-1:0] data_i,
  input  logic [COUNT_WIDTH-1:0]   step_i,
  input  logic                     mute_i,
  output logic                     trig_o,
  output logic                     pending_o
);
  logic [PATTERN_WIDTH-1:0] active_q, active_d, shadow_q, shadow_d, sel_pat;
  logic pend_q, pend_d;
  // Trigger looks at the post-commit pattern so a new bar starts on the new data
  always_comb begin
    active_d = (commit_i && pend_q) ? shadow_q : active_q;
    shadow_d = wr_i ? data_i : shadow_q;
    pend_d   = wr_i || (pend_q && !commit_i);
    sel_pat  = active_d >> step_i;
  end
  assign trig_o    = sel_pat[0] & ~mute_i;
  assign pending_o = pend_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_q <= '0;
      shadow_q <= '0;
      pend_q   <= 1'b0;
    end else begin
      active_q <= active_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
    end
  end
endmodule

// File: rtl/drum_sequencer.sv
// drum_sequencer: multi-drum step sequencer with tempo divider, bar-synchronous
// double-buffered pattern loads and per-drum mute
module drum_sequencer
  import drum_seq_pkg::*;
#(
  parameter int PATTERN_WIDTH = PATTERN_W,
  parameter int COUNT_WIDTH   = 4,
  parameter int DRUM_COUNT    = 5,
  parameter int DIV_WIDTH     = 16,
  localparam int SEL_W        = sel_w(DRUM_COUNT)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en_i_n,
  input  logic [DIV_WIDTH-1:0]     tick_div_i,
  input  logic                     load_i,
  output logic                     load_ready_o,
  input  logic [SEL_W-1:0]         sel_i,
  input  logic [PATTERN_WIDTH-1:0] pattern_i,
  input  logic [DRUM_COUNT-1:0]    mute_i,
  output logic [DRUM_COUNT-1:0]    trig_o,
  output logic [COUNT_WIDTH-1:0]   step_o,
  output logic                     bar_o
);
  localparam logic [COUNT_WIDTH-1:0] LAST = COUNT_WIDTH'(PATTERN_WIDTH - 1);

  if (COUNT_WIDTH < $clog2(PATTERN_WIDTH)) begin : g_bad_cw
    $error("drum_sequencer: COUNT_WIDTH too small for PATTERN_WIDTH");
  end

  seq_state_e state_q, state_d;
  logic [DIV_WIDTH-1:0]   div_q, div_d;
  logic [COUNT_WIDTH-1:0] step_q, step_d;
  logic [DRUM_COUNT-1:0]  trig_q, trig_d, trig_bits, wr, pend;
  logic bar_q, bar_d, run, start, tick, fire, commit;

  always_comb begin
    run     = !en_i_n;
    start   = state_q == IDLE;
    tick    = state_q == RUN && div_q == '0;
    fire    = run && (start || tick);
    commit  = start || (tick && step_q == LAST);
    step_d  = (!run || start) ? '0 : !tick ? step_q : (step_q == LAST) ? '0 : step_q + 1'b1;
    div_d   = !run ? '0 : (start || tick) ? tick_div_i : div_q - 1'b1;
    trig_d  = fire ? trig_bits : '0;
    bar_d   = fire && step_d == '0;
    state_d = run ? RUN : IDLE;
  end

  // Out-of-range selects match no channel, so ready stays high and the write is dropped
  always_comb begin
    wr = '0;
    load_ready_o = 1'b1;
    for (int c = 0; c < DRUM_COUNT; c++) begin
      wr[c] = load_i && !pend[c] && sel_i == SEL_W'(c);
      if (sel_i == SEL_W'(c)) load_ready_o = !pend[c];
    end
  end

  for (genvar i = 0; i < DRUM_COUNT; i++) begin : g_ch
    drum_channel #(
      .PATTERN_WIDTH(PATTERN_WIDTH),
      .COUNT_WIDTH  (COUNT_WIDTH)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .wr_i     (wr[i]),
      .commit_i (commit),
      .data_i   (pattern_i),
      .step_i   (step_d),
      .mute_i   (mute_i[i]),
      .trig_o   (trig_bits[i]),
      .pending_o(pend[i])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      step_q  <= '0;
      trig_q  <= '0;
      bar_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      step_q  <= step_d;
      trig_q  <= trig_d;
      bar_q   <= bar_d;
    end
  end

  assign trig_o = trig_q;
  assign step_o = step_q;
  assign bar_o  = bar_q;
endmodule

// File: tb/tb_drum_sequencer.sv
// tb_drum_sequencer: directed vector table plus hand-written tempo, mute and reset sequences
module tb_drum_sequencer;
  localparam int PW = 8, CW = 4, DC = 4, DW = 8;
  logic clk = 1'b0, rst = 1'b1, en_i_n = 1'b1, load_i = 1'b0;
  logic [DW-1:0] tick_div_i = '0;
  logic [1:0] sel_i = '0;
  logic [PW-1:0] pattern_i = '0;
  logic [DC-1:0] mute_i = '0;
  logic load_ready_o, bar_o;
  logic [DC-1:0] trig_o;
  logic [CW-1:0] step_o;
  int checks = 0, failures = 0;

  drum_sequencer #(.PATTERN_WIDTH(PW), .COUNT_WIDTH(CW), .DRUM_COUNT(DC), .DIV_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .en_i_n(en_i_n), .tick_div_i(tick_div_i), .load_i(load_i),
    .load_ready_o(load_ready_o), .sel_i(sel_i), .pattern_i(pattern_i), .mute_i(mute_i),
    .trig_o(trig_o), .step_o(step_o), .bar_o(bar_o));

  always #5 clk = ~clk;

  typedef struct {
    logic en_n; logic [7:0] div; logic ld; logic [1:0] sel; logic [7:0] pat; logic [3:0] mute;
    logic rdy; logic [3:0] trig; logic [3:0] step; logic bar;
  } vec_t;
  vec_t v[22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //      en div ld sel pat    mute  rdy trig  step bar
    v[0]  = '{1, 0, 1, 0, 8'h05, 0, 1, 4'h0, 0, 0};
    v[1]  = '{1, 0, 0, 0, 8'h00, 0, 0, 4'h0, 0, 0};
    v[2]  = '{1, 0, 0, 0, 8'h00, 0, 1, 4'h0, 0, 0};
    v[3]  = '{0, 0, 0, 0, 8'h00, 0, 1, 4'h1, 0, 1};
    v[4]  = '{0, 0, 0, 0, 8'h00, 0, 1, 4'h0, 1, 0};
    v[5]  = '{0, 0, 0, 0, 8'h00, 0, 1, 4'h1, 2, 0};
    v[6]  = '{0, 0, 1, 1, 8'h80, 0, 1, 4'h0, 3, 0};
    v[7]  = '{0, 0, 1, 1, 8'hFF, 0, 0, 4'h0, 4, 0};
    v[8]  = '{0, 0, 1, 3, 8'h40, 0, 1, 4'h0, 5, 0};
    v[9]  = '{0, 0, 0, 2, 8'h00, 0, 1, 4'h0, 6, 0};
    v[10] = '{0, 0, 0, 1, 8'h00, 0, 0, 4'h0, 7, 0};
    v[11] = '{0, 0, 1, 2, 8'h02, 0, 1, 4'h1, 0, 1};
    v[12] = '{0, 0, 0, 2, 8'h00, 0, 0, 4'h0, 1, 0};
    v[13] = '{0, 0, 0, 1, 8'h00, 0, 1, 4'h1, 2, 0};
    v[14] = '{0, 0, 0, 0, 8'h00, 0, 1, 4'h0, 3, 0};
    v[15] = '{0, 0, 0, 0, 8'h00, 0, 1, 4'h0, 4, 0};
    v[16] = '{0, 0, 0, 0, 8'h00, 0, 1, 4'h0, 5, 0};
    v[17] = '{0, 0, 0, 0, 8'h00, 0, 1, 4'h8, 6, 0};
    v[18] = '{0, 0, 0, 0, 8'h00, 0, 1, 4'h2, 7, 0};
    v[19] = '{0, 0, 0, 2, 8'h00, 0, 0, 4'h1, 0, 1};
    v[20] = '{0, 0, 0, 2, 8'h00, 4'b0100, 1, 4'h0, 1, 0};
    v[21] = '{1, 0, 0, 3, 8'h00, 0, 1, 4'h0, 0, 0};

    #2 rst = 1'b0;
    #1;
    chk("reset_trig", trig_o, 0);
    chk("reset_step", step_o, 0);
    chk("reset_bar", bar_o, 0);
    chk("reset_ready", load_ready_o, 1);
    @(posedge clk);
    #1 rst = 1'b1;

    for (int i = 0; i < 22; i++) begin
      en_i_n = v[i].en_n; tick_div_i = v[i].div; load_i = v[i].ld;
      sel_i = v[i].sel; pattern_i = v[i].pat; mute_i = v[i].mute;
      #1;
      chk($sformatf("vec%0d_ready", i), load_ready_o, v[i].rdy);
      cyc();
      chk($sformatf("vec%0d_trig", i), trig_o, v[i].trig);
      chk($sformatf("vec%0d_step", i), step_o, v[i].step);
      chk($sformatf("vec%0d_bar", i), bar_o, v[i].bar);
    end
    load_i = 1'b0;

    // tick_div=3: steps 4 cycles apart, ch0=05 fires at steps 0 and 2, bar every 32 cycles
    tick_div_i = 8'd3; mute_i = 4'b1110; en_i_n = 1'b0;
    cyc();
    chk("div3_start", {trig_o, step_o, bar_o}, {4'h1, 4'd0, 1'b1});
    for (int i = 1; i <= 64; i++) begin
      automatic int s = (i / 4) % 8;
      automatic logic f = (i % 4) == 0;
      automatic logic t0 = f && (s == 0 || s == 2);
      cyc();
      chk($sformatf("div3_c%0d", i), {trig_o, step_o, bar_o}, {3'b0, t0, 4'(s), f && s == 0});
    end
    en_i_n = 1'b1;
    cyc();
    chk("stop_clear", {trig_o, step_o, bar_o}, 0);

    // mute ch3 (reloaded to FF) while steps continue, unmute during step 5
    load_i = 1'b1; sel_i = 2'd3; pattern_i = 8'hFF; mute_i = 4'b1000;
    cyc();
    load_i = 1'b0;
    cyc();
    tick_div_i = 8'd0; en_i_n = 1'b0;
    cyc();
    chk("mute_start", {trig_o[3], step_o, bar_o}, {1'b0, 4'd0, 1'b1});
    for (int k = 1; k <= 5; k++) begin
      cyc();
      chk($sformatf("mute_step%0d", k), {trig_o[3], step_o, bar_o}, {1'b0, 4'(k), 1'b0});
    end
    mute_i = 4'b0000;
    cyc();
    chk("unmute_step6", {trig_o[3], step_o}, {1'b1, 4'd6});
    en_i_n = 1'b1;
    cyc();

    // slowest tempo: 256 cycles per step
    tick_div_i = 8'd255; en_i_n = 1'b0;
    cyc();
    for (int i = 1; i <= 512; i++) begin
      cyc();
      if (i == 255) chk("div255_c255", step_o, 0);
      if (i == 256) chk("div255_c256", {step_o, bar_o}, {4'd1, 1'b0});
      if (i == 511) chk("div255_c511", step_o, 1);
      if (i == 512) chk("div255_c512", step_o, 2);
    end
    en_i_n = 1'b1;
    cyc();

    // async reset mid-cycle with a pending load; patterns must come back as zero
    tick_div_i = 8'd0; en_i_n = 1'b0;
    cyc();
    load_i = 1'b1; sel_i = 2'd1; pattern_i = 8'h01;
    cyc();
    load_i = 1'b0;
    #1;
    chk("pre_rst_out", {trig_o, step_o}, {4'b1100, 4'd1});
    chk("pre_rst_ready", load_ready_o, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("async_rst_out", {trig_o, step_o, bar_o}, 0);
    chk("async_rst_ready", load_ready_o, 1);
    #2 rst = 1'b1;
    cyc();
    chk("post_rst_start", {trig_o, step_o, bar_o}, {4'h0, 4'd0, 1'b1});
    cyc();
    chk("post_rst_step1", {trig_o, step_o}, {4'h0, 4'd1});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
